// File: rtl/fp_addsub_seq_ctrl.sv
// fp_addsub_seq_ctrl
//   Issue/return sequencer wrapped around an external fixed-latency FP add/sub
//   core. Operands are negative-zero normalised and presented to the core in
//   the accept cycle. A CORE_LAT-deep shift register tracks each request's
//   valid/tag/accumulate flag. The core result is captured when the entry
//   exits, and is published one edge later as a one-cycle finish pulse
//   (CORE_LAT+1 edges after the accept edge). An accumulate mode feeds the
//   last accumulate result back as operand b. A hold register gives a
//   controllable copy of the result.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start/ready              request handshake (accept = start & ready)
//   a, b, op, tag_in         operands, 0=add/1=sub, request tag
//   acc_mode, acc_clear      use accumulator as b / zero the accumulator
//   core_a, core_b, core_op  to external core
//   core_res                 from external core, valid when the entry exits
//   result, finish, tag_out  registered result, 1-cycle valid, its tag
//   hold_en, iteration_reinitialization, held_out  hold register control/output
//   busy, in_flight          outstanding request status
module fp_addsub_seq_ctrl #(
    parameter  int EXP_W    = 8,
    parameter  int MAN_W    = 23,
    parameter  int CORE_LAT = 3,
    parameter  int TAG_W    = 4,
    localparam int W        = 1 + EXP_W + MAN_W,
    localparam int CNT_W    = $clog2(CORE_LAT + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             op,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             acc_mode,
    input  logic             acc_clear,
    output logic [W-1:0]     core_a,
    output logic [W-1:0]     core_b,
    output logic             core_op,
    input  logic [W-1:0]     core_res,
    output logic [W-1:0]     result,
    output logic             finish,
    output logic [TAG_W-1:0] tag_out,
    input  logic             hold_en,
    input  logic             iteration_reinitialization,
    output logic [W-1:0]     held_out,
    output logic             busy,
    output logic [CNT_W-1:0] in_flight
);

    // -0 (sign set, everything else zero) is folded onto +0
    function automatic logic [W-1:0] nz(input logic [W-1:0] x);
        return (x[W-2:0] == '0) ? '0 : x;
    endfunction

    logic [CORE_LAT-1:0]            vld_pipe;
    logic [CORE_LAT-1:0]            acc_pipe;
    logic [CORE_LAT-1:0][TAG_W-1:0] tag_pipe;

    // return stage: core result captured as its entry leaves the pipe
    logic             ret_vld;
    logic             ret_acc;
    logic [TAG_W-1:0] ret_tag;
    logic [W-1:0]     ret_res;

    logic [W-1:0]     acc_q;
    logic [W-1:0]     hold_reg;
    logic             accept;

    // accumulate requests depend on the previous result, so they wait for an
    // empty pipe; plain requests stream one per cycle
    assign ready    = !rst && (acc_mode ? (in_flight == '0) : 1'b1);
    assign accept   = start && ready;

    assign core_a   = nz(a);
    assign core_b   = acc_mode ? acc_q : nz(b);
    assign core_op  = op;

    assign busy     = (in_flight != '0);
    assign held_out = hold_en ? result : hold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            acc_pipe  <= '0;
            tag_pipe  <= '0;
            ret_vld   <= 1'b0;
            ret_acc   <= 1'b0;
            ret_tag   <= '0;
            ret_res   <= '0;
            finish    <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
            in_flight <= '0;
            acc_q     <= '0;
            hold_reg  <= '0;
        end else begin
            vld_pipe[0] <= accept;
            acc_pipe[0] <= acc_mode;
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < CORE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                acc_pipe[i] <= acc_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end

            ret_vld <= vld_pipe[CORE_LAT-1];
            if (vld_pipe[CORE_LAT-1]) begin
                ret_acc <= acc_pipe[CORE_LAT-1];
                ret_tag <= tag_pipe[CORE_LAT-1];
                ret_res <= nz(core_res);
            end

            finish <= ret_vld;
            if (ret_vld) begin
                result  <= ret_res;
                tag_out <= ret_tag;
            end

            // count drops on the edge that raises finish
            case ({accept, ret_vld})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= in_flight - CNT_W'(1);
                default: in_flight <= in_flight;
            endcase

            if (acc_clear)
                acc_q <= '0;
            else if (ret_vld && ret_acc)
                acc_q <= ret_res;

            if (hold_en)
                hold_reg <= result;
            else if (!iteration_reinitialization)
                hold_reg <= '0;
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq_ctrl.sv
// Bench for fp_addsub_seq_ctrl: models a CORE_LAT-deep FP core for integer-
// valued single-precision operands, issues directed vectors and checks results
// through a scoreboard queue drained by a finish monitor.
module tb_fp_addsub_seq_ctrl;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int CORE_LAT = 3;
    localparam int TAG_W    = 4;
    localparam int W        = 32;
    localparam int CNT_W    = $clog2(CORE_LAT + 2);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             ready;
    logic [W-1:0]     a, b;
    logic             op;
    logic [TAG_W-1:0] tag_in;
    logic             acc_mode, acc_clear;
    logic [W-1:0]     core_a, core_b;
    logic             core_op;
    logic [W-1:0]     core_res;
    logic [W-1:0]     result;
    logic             finish;
    logic [TAG_W-1:0] tag_out;
    logic             hold_en, reinit;
    logic [W-1:0]     held_out;
    logic             busy;
    logic [CNT_W-1:0] in_flight;

    fp_addsub_seq_ctrl #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CORE_LAT(CORE_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .a(a), .b(b), .op(op),
        .tag_in(tag_in), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_res(core_res),
        .result(result), .finish(finish), .tag_out(tag_out), .hold_en(hold_en),
        .iteration_reinitialization(reinit), .held_out(held_out),
        .busy(busy), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fin_cnt  = 0;
    int peak     = 0;
    bit force_negz = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---- core model: exact for small integer-valued floats ----
    function automatic int f2i(input logic [31:0] x);
        int e;
        logic [31:0] m;
        if (x[30:0] == 31'd0) return 0;
        e = int'(x[30:23]);
        m = {8'd0, 1'b1, x[22:0]};
        m = m >> (150 - e);
        return x[31] ? -int'(m) : int'(m);
    endfunction

    function automatic logic [31:0] i2f(input int v);
        logic        s;
        logic [31:0] u, m;
        int          p;
        if (v == 0) return 32'd0;
        s = (v < 0);
        u = s ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 31; i++) if (u[i]) p = i;
        m = u << (23 - p);
        return {s, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [31:0] core_fn(input logic [31:0] x, input logic [31:0] y,
                                            input logic o, input bit negz);
        int r;
        r = o ? (f2i(x) - f2i(y)) : (f2i(x) + f2i(y));
        if (r == 0 && negz) return 32'h8000_0000;
        return i2f(r);
    endfunction

    logic [31:0] cpipe [CORE_LAT];
    always @(posedge clk) begin
        cpipe[0] <= core_fn(core_a, core_b, core_op, force_negz);
        for (int i = 1; i < CORE_LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign core_res = cpipe[CORE_LAT-1];

    // ---- checking ----
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               c;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (finish) begin
            exp_t e;
            fin_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_finish", 32'(tag_out), 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("tag_out", 32'(tag_out), 32'(e.tag));
                chk("finish_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    // ---- stimulus ----
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                         input logic [TAG_W-1:0] itag, input logic iacc,
                         input logic [31:0] eca, input logic [31:0] ecb,
                         input logic [31:0] eres, input bit want);
        bit ok = 1'b0;
        a = ia; b = ib; op = iop; tag_in = itag; acc_mode = iacc; start = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (int'(in_flight) > peak) peak = int'(in_flight);
            if (ready) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) fail_now("accept_wait");
        else begin
            chk("core_a", core_a, eca);
            chk("core_b", core_b, ecb);
            chk("core_op", 32'(core_op), 32'(iop));
            if (want) sbq.push_back('{eres, itag, cyc + CORE_LAT + 2});
        end
        @(posedge clk); #1;
        start = 1'b0; acc_mode = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (int'(in_flight) > peak) peak = int'(in_flight);
            if (sbq.size() == 0 && in_flight == '0) ok = 1'b1;
        end
        if (!ok) fail_now("idle_wait");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        bit ok;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = 1'b0; tag_in = '0;
        acc_mode = 1'b0; acc_clear = 1'b0; hold_en = 1'b0; reinit = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag_out", 32'(tag_out), 32'd0);
        chk("rst_held_out", held_out, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1.0 + 2.0
        f0 = fin_cnt;
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5, 1'b0,
              32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
        wait_idle();
        chk("single_finish_count", 32'(fin_cnt - f0), 32'd1);

        // four back-to-back requests, tags 1..4
        peak = 0; f0 = fin_cnt;
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd1, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        issue(32'h4000_0000, 32'h3F80_0000, 1'b0, 4'd2, 1'b0, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 1'b1);
        issue(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd3, 1'b0, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        issue(32'h4000_0000, 32'h4040_0000, 1'b1, 4'd4, 1'b0, 32'h4000_0000, 32'h4040_0000, 32'hBF80_0000, 1'b1);
        wait_idle();
        chk("b2b_peak_in_flight", 32'(peak), 32'd4);
        chk("b2b_finish_count", 32'(fin_cnt - f0), 32'd4);
        chk("b2b_in_flight_end", 32'(in_flight), 32'd0);

        // negative-zero operands
        issue(32'h8000_0000, 32'h3F80_0000, 1'b1, 4'd6, 1'b0, 32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b1);
        issue(32'h4000_0000, 32'h8000_0000, 1'b0, 4'd8, 1'b0, 32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1);
        wait_idle();

        // core returns -0: result must come out as +0
        force_negz = 1'b1;
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 4'd9, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1);
        wait_idle();
        force_negz = 1'b0;

        // accumulate: 0+1, 1+1, 2+1
        acc_clear = 1'b1; @(posedge clk); #1 acc_clear = 1'b0;
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd10, 1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b1);
        a = 32'h3F80_0000; acc_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("acc_ready_while_busy", 32'(ready), 32'd0);
        chk("acc_busy", 32'(busy), 32'd1);
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd11, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd12, 1'b1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
        wait_idle();
        chk("acc_final_result", result, 32'h4040_0000);
        acc_clear = 1'b1; @(posedge clk); #1 acc_clear = 1'b0;
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd13, 1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b1);
        wait_idle();

        // hold register
        hold_en = 1'b1; reinit = 1'b1;
        issue(32'h4000_0000, 32'h4000_0000, 1'b0, 4'd7, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (finish) ok = 1'b1;
        end
        if (!ok) fail_now("hold_finish_wait");
        chk("hold_pass", held_out, 32'h4080_0000);
        @(posedge clk); #1 hold_en = 1'b0;
        @(negedge clk); chk("hold_keep0", held_out, 32'h4080_0000);
        @(posedge clk); #1;
        @(negedge clk); chk("hold_keep1", held_out, 32'h4080_0000);
        @(posedge clk); #1 reinit = 1'b0;
        @(negedge clk); chk("hold_before_clear", held_out, 32'h4080_0000);
        @(negedge clk); chk("hold_cleared", held_out, 32'h0000_0000);
        @(posedge clk); #1 reinit = 1'b1; hold_en = 1'b1;

        // reset with a request in flight
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd3, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        @(posedge clk); #1 rst = 1'b1; hold_en = 1'b0;
        @(negedge clk); chk("ready_in_rst", 32'(ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        f0 = fin_cnt;
        repeat (8) @(negedge clk);
        chk("post_rst_no_finish", 32'(fin_cnt - f0), 32'd0);
        chk("post_rst_result", result, 32'd0);
        chk("post_rst_tag_out", 32'(tag_out), 32'd0);
        chk("post_rst_in_flight", 32'(in_flight), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_held_out", held_out, 32'd0);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
